result_serializer: RTL and testbench

- Downstream of the convolution layer stage; consumes its wide result word (DEPTH_NB lanes of IMG_WIDTH) over a val/rdy handshake.
- Buffers up to two words and streams each as LANE_NB-lane beats, with a last flag on the final beat, toward the output DMA.
- Beat count per word is configurable over the shared cfg bus, so layers using fewer output channels emit fewer beats.

---
 rtl/result_serializer.sv | 125 ++++++++++++
 tb/tb_result_serializer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Result word serializer: 2-entry word FIFO streamed out as LANE_NB-lane beats with a last flag.
// Optional macro RESULT_SERIALIZER_RELU_EN clamps negative lanes to zero on the output beat.
module result_serializer #(
    parameter int CFG_DWIDTH     = 32,
    parameter int CFG_AWIDTH     = 5,
    parameter int CFG_BEATS_ADDR = 9,
    parameter int DEPTH_NB       = 16,
    parameter int LANE_NB        = 4,
    parameter int IMG_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [IMG_WIDTH*DEPTH_NB-1:0] result_bus,
    input  logic                          result_val,
    output logic                          result_rdy,
    output logic [IMG_WIDTH*LANE_NB-1:0]  str_bus,
    output logic                          str_val,
    output logic                          str_last,
    input  logic                          str_rdy
);

    localparam int BEATS  = DEPTH_NB / LANE_NB;
    localparam int WORD_W = IMG_WIDTH * DEPTH_NB;
    localparam int BEAT_W = IMG_WIDTH * LANE_NB;
    localparam logic [7:0] BEATS_L = 8'(BEATS);
    localparam logic [CFG_AWIDTH-1:0] BEATS_ADDR = CFG_AWIDTH'(CFG_BEATS_ADDR);

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count, count_d;
    logic              rdy_q;
    logic [7:0]        beat, beats_lim, cur_lim, limit, cfg_lim;
    logic              push, pop, beat_acc;
    logic [BEAT_W-1:0] beat_data;
    logic              cfg_unused;

    assign cfg_unused = ^cfg_data[CFG_DWIDTH-1:8];

    assign result_rdy = rdy_q;
    assign str_val    = (count != 2'd0);
    assign push       = result_val && rdy_q;
    // Beat 0 sees the live limit so a cfg write before a word starts takes effect on it.
    assign limit      = (beat == 8'd0) ? beats_lim : cur_lim;
    assign str_last   = str_val && (beat == limit - 8'd1);
    assign beat_acc   = str_val && str_rdy;
    assign pop        = beat_acc && str_last;

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + 2'd1;
        end else if (!push && pop) begin
            count_d = count - 2'd1;
        end
    end

    always_comb begin
        cfg_lim = cfg_data[7:0];
        if (cfg_data[7:0] == 8'd0 || cfg_data[7:0] > BEATS_L) begin
            cfg_lim = BEATS_L;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            rdy_q     <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            beat      <= 8'd0;
            cur_lim   <= 8'd0;
            beats_lim <= BEATS_L;
        end else begin
            count <= count_d;
            // Registered ready mirrors count_d so it never depends on result_val/str_rdy.
            rdy_q <= (count_d != 2'd2);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                beat   <= 8'd0;
            end else if (beat_acc) begin
                beat <= beat + 8'd1;
            end
            if (beat_acc && beat == 8'd0) begin
                cur_lim <= beats_lim;
            end
            if (cfg_valid && cfg_addr == BEATS_ADDR) begin
                beats_lim <= cfg_lim;
            end
        end
    end

    // Storage is masked by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result_bus;
        end
    end

    always_comb begin
        beat_data = '0;
        if (str_val) begin
            beat_data = mem[rd_ptr][int'(beat) * BEAT_W +: BEAT_W];
        end
    end

`ifdef RESULT_SERIALIZER_RELU_EN
    always_comb begin
        str_bus = '0;
        for (int l = 0; l < LANE_NB; l++) begin
            if (!beat_data[(l + 1) * IMG_WIDTH - 1]) begin
                str_bus[l * IMG_WIDTH +: IMG_WIDTH] = beat_data[l * IMG_WIDTH +: IMG_WIDTH];
            end
        end
    end
`else
    assign str_bus = beat_data;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: stimulus enqueues expected beats, a monitor checks them.
module tb_result_serializer;

    localparam int WW = 256;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cfg_data;
    logic [4:0]    cfg_addr;
    logic          cfg_valid;
    logic [WW-1:0] result_bus;
    logic          result_val;
    logic          result_rdy;
    logic [BW-1:0] str_bus;
    logic          str_val;
    logic          str_last;
    logic          str_rdy;

    typedef struct packed {
        logic [BW-1:0] bus;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            beats_seen = 0;
    int            model_lim = 4;
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_bus;
    logic          prev_last;
    logic          tog_stop;
    int            seen0;

    result_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .result_bus (result_bus),
        .result_val (result_val),
        .result_rdy (result_rdy),
        .str_bus    (str_bus),
        .str_val    (str_val),
        .str_last   (str_last),
        .str_rdy    (str_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] exp_beat(input logic [WW-1:0] w, input int k);
        logic [BW-1:0] b;
        b = w[k * BW +: BW];
`ifdef RESULT_SERIALIZER_RELU_EN
        for (int l = 0; l < 4; l++) begin
            if (b[l * 16 + 15]) b[l * 16 +: 16] = 16'h0000;
        end
`endif
        return b;
    endfunction

    function automatic logic [WW-1:0] mk_word(input int base);
        logic [WW-1:0] w;
        for (int i = 0; i < 16; i++) w[i * 16 +: 16] = 16'(base + i + 1);
        return w;
    endfunction

    task automatic push(input logic [WW-1:0] w);
        int n;
        exp_t e;
        result_bus = w;
        result_val = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (result_rdy) break;
            n++;
            if (n > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL push_timeout: result_rdy stuck 0, required 1");
                result_val = 1'b0;
                return;
            end
        end
        @(posedge clk);
        for (int k = 0; k < model_lim; k++) begin
            e.bus  = exp_beat(w, k);
            e.last = (k == model_lim - 1);
            exp_q.push_back(e);
        end
        #1 result_val = 1'b0;
    endtask

    task automatic cfg_write(input logic [31:0] d);
        @(posedge clk);
        #1 cfg_valid = 1'b1;
        cfg_addr = 5'd9;
        cfg_data = d;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        model_lim = (d[7:0] == 8'd0 || d[7:0] > 8'd4) ? 4 : int'(d[7:0]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            n++;
            if (n > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
                exp_q.delete();
            end
        end
        #1;
    endtask

    // Monitor: pop/compare on every accepted beat, and check stability through stalls.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_bus", str_bus, prev_bus);
                check("stall_last", BW'(str_last), BW'(prev_last));
            end
            if (str_val && str_rdy) begin
                exp_t e;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h, required no beat", str_bus);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_bus", str_bus, e.bus);
                    check("beat_last", BW'(str_last), BW'(e.last));
                end
            end
            prev_stall = str_val && !str_rdy;
            prev_bus   = str_bus;
            prev_last  = str_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WW-1:0] rw;
        rst = 1'b1;
        cfg_data = '0;
        cfg_addr = '0;
        cfg_valid = 1'b0;
        result_bus = '0;
        result_val = 1'b0;
        str_rdy = 1'b0;
        tog_stop = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", BW'(result_rdy), '0);
        check("rst_val", BW'(str_val), '0);
        check("rst_last", BW'(str_last), '0);
        check("rst_bus", str_bus, '0);
        @(negedge clk) rst = 1'b0;
        #1 check("rdy_before_edge", BW'(result_rdy), '0);
        @(posedge clk);
        #1 check("rdy_after_rst", BW'(result_rdy), 64'd1);

        // One word, 4 consecutive beats
        str_rdy = 1'b1;
        push(mk_word(0));
        check("t1_beat0_literal", str_bus, 64'h0004_0003_0002_0001);
        check("t1_val", BW'(str_val), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("t1_done_pending", BW'(exp_q.size()), '0);
        check("t1_idle_val", BW'(str_val), '0);

        // Backpressure: two words fill the buffer, the third waits upstream
        @(posedge clk);
        #1 str_rdy = 1'b0;
        push(mk_word(16));
        push(mk_word(32));
        @(negedge clk);
        check("t2_full_rdy", BW'(result_rdy), '0);
        fork
            push(mk_word(48));
            begin
                repeat (3) @(posedge clk);
                #1 str_rdy = 1'b1;
            end
        join
        wait_drain();
        check("t2_rdy_after", BW'(result_rdy), 64'd1);

        // Beat limit via cfg
        cfg_write(32'd2);
        push(mk_word(80));
        wait_drain();
        cfg_write(32'd0);
        push(mk_word(96));
        wait_drain();
        push(mk_word(112));
        cfg_write(32'd1);
        wait_drain();
        push(mk_word(128));
        wait_drain();
        cfg_write(32'd7);
        push(mk_word(144));
        wait_drain();

        // Random backpressure over 10 words
        seen0 = beats_seen;
        fork
            begin
                for (int j = 0; j < 10; j++) push(mk_word(64 + 16 * j));
                wait_drain();
                tog_stop = 1'b1;
            end
            begin
                while (!tog_stop) begin
                    @(posedge clk);
                    #1 str_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        check("t4_beat_count", BW'(beats_seen - seen0), 64'd40);

        // Reset mid-word with a second word queued
        @(posedge clk);
        #1 str_rdy = 1'b0;
        push(mk_word(200));
        push(mk_word(220));
        @(posedge clk);
        #1 str_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        check("t5_val", BW'(str_val), '0);
        check("t5_rdy", BW'(result_rdy), '0);
        check("t5_last", BW'(str_last), '0);
        check("t5_bus", str_bus, '0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rdy_after", BW'(result_rdy), 64'd1);
        repeat (3) @(posedge clk);
        #1 check("t5_no_stale", BW'(str_val), '0);
        model_lim = 4;
        push(mk_word(10));
        wait_drain();

        // ReLU lanes
        for (int i = 0; i < 4; i++) begin
            rw[i * 64 +: 64] = 64'h7FFF_0000_FFFF_8000;
        end
        push(rw);
`ifdef RESULT_SERIALIZER_RELU_EN
        check("t6_relu_beat0", str_bus, 64'h7FFF_0000_0000_0000);
`else
        check("t6_pass_beat0", str_bus, 64'h7FFF_0000_FFFF_8000);
`endif
        wait_drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
